// File: rtl/wb_multiport_ram.sv
// NPORT Wishbone B4 slave ports sharing one word-addressed RAM: wait states, CTI/BTE bursts and
// ERR on out-of-range addresses. Define WB_RAM_STALL_INJECT_EN for LFSR-driven per-beat stalls.
module wb_multiport_ram #(
    parameter int unsigned NPORT       = 2,
    parameter int unsigned ADDR_WIDTH  = 24,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NPORT*32-1:0] wbs_addr_i,
    input  logic [NPORT*32-1:0] wbs_dat_i,
    input  logic [NPORT*4-1:0]  wbs_sel_i,
    input  logic [NPORT-1:0]    wbs_cyc_i,
    input  logic [NPORT-1:0]    wbs_stb_i,
    input  logic [NPORT-1:0]    wbs_we_i,
    input  logic [NPORT*3-1:0]  wbs_cti_i,
    input  logic [NPORT*2-1:0]  wbs_bte_i,
    output logic [NPORT*32-1:0] wbs_dat_o,
    output logic [NPORT-1:0]    wbs_ack_o,
    output logic [NPORT-1:0]    wbs_err_o
);
    localparam int unsigned WordW = ADDR_WIDTH - 2;
    localparam int unsigned Depth = 2 ** WordW;

    typedef enum logic [1:0] {StIdle, StWait, StBeat, StBurst} state_e;

    logic [31:0]      mem [Depth];
    logic [NPORT-1:0] wr_en;
    logic [WordW-1:0] wr_word [NPORT];

    function automatic logic in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return (off >> ADDR_WIDTH) == 32'd0;
    endfunction

    function automatic logic [WordW-1:0] word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return off[ADDR_WIDTH-1:2];
    endfunction

    // Wrapping bursts keep the upper bits and advance only inside the aligned block.
    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] bte);
        logic [31:0] m;
        case (bte)
            2'b01:   m = 32'h0000_000F;
            2'b10:   m = 32'h0000_001F;
            2'b11:   m = 32'h0000_003F;
            default: m = 32'hFFFF_FFFF;
        endcase
        return (a & ~m) | ((a + 32'd4) & m);
    endfunction

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        logic        cyc, stb;
        logic [2:0]  cti;
        logic [1:0]  bte;
        state_e      state_q, state_d;
        logic [31:0] addr_q, addr_d;
        logic [3:0]  wcnt_q, wcnt_d;
        logic        ack_q, ack_d, err_q, err_d;
        logic [31:0] dat_q;
        logic        start, beat_done;

        assign cyc       = wbs_cyc_i[p];
        assign stb       = wbs_stb_i[p];
        assign cti       = wbs_cti_i[p*3 +: 3];
        assign bte       = wbs_bte_i[p*2 +: 2];
        assign beat_done = (ack_q || err_q) && cyc && stb;

`ifdef WB_RAM_STALL_INJECT_EN
        logic [15:0] lfsr_q;
        logic [1:0]  stall_q, stall_d;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                lfsr_q  <= 16'hACE1 ^ 16'(p);
                stall_q <= '0;
            end else begin
                lfsr_q  <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
                stall_q <= stall_d;
            end
        end
`endif

        always_comb begin
            state_d = state_q;
            addr_d  = addr_q;
            wcnt_d  = wcnt_q;
            ack_d   = 1'b0;
            err_d   = 1'b0;
            start   = 1'b0;
`ifdef WB_RAM_STALL_INJECT_EN
            stall_d = stall_q;
`endif
            case (state_q)
                StIdle: begin
                    if (cyc && stb) begin
                        addr_d = wbs_addr_i[p*32 +: 32];
                        wcnt_d = '0;
                        if (WAIT_CYCLES > 0) begin
                            state_d = StWait;
                        end else begin
                            state_d = StBeat;
                            start   = 1'b1;
                        end
                    end
                end
                StWait: begin
                    if (wcnt_q == 4'(WAIT_CYCLES - 1)) begin
                        state_d = StBeat;
                        start   = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + 4'd1;
                    end
                end
                default: begin
                    if (beat_done) begin
                        if (err_q || cti != 3'b010) begin
                            state_d = StIdle;
                        end else begin
                            state_d = StBurst;
                            addr_d  = next_addr(addr_q, bte);
                            start   = 1'b1;
                        end
                    end else if (ack_q || err_q) begin
                        // Burst beat offered but stb low: keep it offered, address held.
                        if (state_q == StBurst) begin
                            ack_d = ack_q;
                            err_d = err_q;
                        end else begin
                            state_d = StIdle;
                        end
                    end
`ifdef WB_RAM_STALL_INJECT_EN
                    else if (stall_q != 2'd0) begin
                        stall_d = stall_q - 2'd1;
                        if (stall_q == 2'd1) begin
                            ack_d = in_range(addr_q);
                            err_d = !in_range(addr_q);
                        end
                    end
`endif
                end
            endcase

            if (start) begin
`ifdef WB_RAM_STALL_INJECT_EN
                if (lfsr_q[1:0] != 2'd0) begin
                    stall_d = lfsr_q[1:0];
                end else begin
                    ack_d = in_range(addr_d);
                    err_d = !in_range(addr_d);
                end
`else
                ack_d = in_range(addr_d);
                err_d = !in_range(addr_d);
`endif
            end

            if (state_q != StIdle && !cyc) begin
                state_d = StIdle;
                ack_d   = 1'b0;
                err_d   = 1'b0;
`ifdef WB_RAM_STALL_INJECT_EN
                stall_d = '0;
`endif
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= StIdle;
                addr_q  <= '0;
                wcnt_q  <= '0;
                ack_q   <= 1'b0;
                err_q   <= 1'b0;
                dat_q   <= '0;
            end else begin
                state_q <= state_d;
                addr_q  <= addr_d;
                wcnt_q  <= wcnt_d;
                ack_q   <= ack_d;
                err_q   <= err_d;
                dat_q   <= ack_d ? mem[word_of(addr_d)] : 32'd0;
            end
        end

        assign wbs_ack_o[p]          = ack_q && cyc && stb;
        assign wbs_err_o[p]          = err_q && cyc && stb;
        assign wbs_dat_o[p*32 +: 32] = dat_q;
        assign wr_en[p]              = ack_q && cyc && stb && wbs_we_i[p];
        assign wr_word[p]            = word_of(addr_q);
    end

    // Ascending port order: the highest-index writer of a byte lands last and wins.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NPORT; p++) begin
            if (wr_en[p]) begin
                for (int b = 0; b < 4; b++) begin
                    if (wbs_sel_i[p*4 + b]) begin
                        mem[wr_word[p]][b*8 +: 8] <= wbs_dat_i[p*32 + b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_multiport_ram.sv
// Directed bench for wb_multiport_ram: two instances (0 and 3 wait states), table vectors plus
// hand sequences for collisions, wrap bursts, reset mid-burst and optional stall injection.
module tb_wb_multiport_ram;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Index 0 drives u_dut0 (no wait states), index 1 drives u_dut3 (three wait states).
    logic [63:0] adr [2];
    logic [63:0] dti [2];
    logic [7:0]  sel [2];
    logic [1:0]  cyc [2];
    logic [1:0]  stb [2];
    logic [1:0]  we  [2];
    logic [5:0]  cti [2];
    logic [3:0]  bte [2];
    logic [63:0] dto0, dto3;
    logic [1:0]  ack0, ack3, err0, err3;

    int n_checks = 0;
    int n_fail   = 0;

    wb_multiport_ram #(
        .NPORT(2), .ADDR_WIDTH(24), .BASE_ADDR(32'h8000_0000), .WAIT_CYCLES(0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .wbs_addr_i(adr[0]), .wbs_dat_i(dti[0]), .wbs_sel_i(sel[0]),
        .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]), .wbs_we_i(we[0]), .wbs_cti_i(cti[0]),
        .wbs_bte_i(bte[0]), .wbs_dat_o(dto0), .wbs_ack_o(ack0), .wbs_err_o(err0)
    );

    wb_multiport_ram #(
        .NPORT(2), .ADDR_WIDTH(24), .BASE_ADDR(32'h8000_0000), .WAIT_CYCLES(3)
    ) u_dut3 (
        .clk(clk), .rst(rst), .wbs_addr_i(adr[1]), .wbs_dat_i(dti[1]), .wbs_sel_i(sel[1]),
        .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]), .wbs_we_i(we[1]), .wbs_cti_i(cti[1]),
        .wbs_bte_i(bte[1]), .wbs_dat_o(dto3), .wbs_ack_o(ack3), .wbs_err_o(err3)
    );

`ifdef WB_RAM_STALL_INJECT_EN
    // Reference LFSR for u_dut0 port 0; m_prev is the value the DUT saw at the last edge.
    logic [15:0] m_lfsr, m_prev;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
            m_prev <= m_lfsr;
        end
    end
`endif

    function automatic logic o_ack(input int d, input int p);
        return (d == 0) ? ack0[p] : ack3[p];
    endfunction

    function automatic logic o_err(input int d, input int p);
        return (d == 0) ? err0[p] : err3[p];
    endfunction

    function automatic logic [31:0] o_dat(input int d, input int p);
        return (d == 0) ? dto0[p*32 +: 32] : dto3[p*32 +: 32];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    // Classic single transfer; called and returns at #1 after a rising edge.
    task automatic wb_xfer(input int d, input int p, input logic w, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] s, output logic [31:0] rd,
                           output logic ak, output logic er, output int lat);
        adr[d][p*32 +: 32] = a;
        dti[d][p*32 +: 32] = wd;
        sel[d][p*4 +: 4]   = s;
        cti[d][p*3 +: 3]   = 3'b000;
        bte[d][p*2 +: 2]   = 2'b00;
        we[d][p]  = w;
        cyc[d][p] = 1'b1;
        stb[d][p] = 1'b1;
        lat = -1;
        rd  = '0;
        ak  = 1'b0;
        er  = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (o_ack(d, p) || o_err(d, p)) begin
                lat = i;
                rd  = o_dat(d, p);
                ak  = o_ack(d, p);
                er  = o_err(d, p);
                break;
            end
        end
        @(posedge clk);
        #1;
        cyc[d][p] = 1'b0;
        stb[d][p] = 1'b0;
        we[d][p]  = 1'b0;
    endtask

    // Both ports of u_dut0 hit the same word in the same cycle; wm selects which ports write.
    task automatic dual_op(input string tag, input logic [31:0] a, input logic [1:0] wm,
                           input logic [31:0] v0, input logic [3:0] s0, input logic [31:0] v1,
                           input logic [3:0] s1, output logic [31:0] rd0);
        logic seen;
        seen   = 1'b0;
        rd0    = '0;
        adr[0] = {a, a};
        dti[0] = {v1, v0};
        sel[0] = {s1, s0};
        cti[0] = '0;
        bte[0] = '0;
        we[0]  = wm;
        cyc[0] = 2'b11;
        stb[0] = 2'b11;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = ack0[0] || ack0[1];
        end
        check({tag, "_acks"}, 32'(ack0), 32'h3);
        rd0 = dto0[31:0];
        @(posedge clk);
        #1;
        cyc[0] = 2'b00;
        stb[0] = 2'b00;
        we[0]  = 2'b00;
    endtask

    typedef struct {
        int          d;
        int          p;
        logic        w;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  s;
        logic [31:0] exp_rd;
        logic        exp_ack;
        int          exp_lat;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    initial begin
        logic [31:0] rd;
        logic        ak, er;
        int          lat;
        logic [31:0] exp_w [4];

        for (int d = 0; d < 2; d++) begin
            adr[d] = '0; dti[d] = '0; sel[d] = '0; cyc[d] = '0;
            stb[d] = '0; we[d]  = '0; cti[d] = '0; bte[d] = '0;
        end

        vecs[0]  = '{0, 1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,          1'b1, 1};
        vecs[1]  = '{0, 0, 1'b0, 32'h8000_0010, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b1, 1};
        vecs[2]  = '{0, 0, 1'b1, 32'h8000_0000, 32'h0BAD_F00D, 4'hF, 32'h0,          1'b1, 1};
        vecs[3]  = '{0, 0, 1'b0, 32'h7FFF_FFFC, 32'h0,         4'hF, 32'h0,          1'b0, 1};
        vecs[4]  = '{0, 1, 1'b0, 32'h8100_0000, 32'h0,         4'hF, 32'h0,          1'b0, 1};
        vecs[5]  = '{0, 1, 1'b1, 32'h8100_0000, 32'h5555_5555, 4'hF, 32'h0,          1'b0, 1};
        vecs[6]  = '{0, 1, 1'b0, 32'h8000_0000, 32'h0,         4'hF, 32'h0BAD_F00D, 1'b1, 1};
        vecs[7]  = '{0, 0, 1'b1, 32'h80FF_FFFC, 32'h1234_5678, 4'hF, 32'h0,          1'b1, 1};
        vecs[8]  = '{0, 1, 1'b0, 32'h80FF_FFFF, 32'h0,         4'hF, 32'h1234_5678, 1'b1, 1};
        vecs[9]  = '{1, 0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,          1'b1, 4};
        vecs[10] = '{1, 1, 1'b1, 32'h8000_0010, 32'h0000_AA00, 4'h2, 32'h0,          1'b1, 4};
        vecs[11] = '{1, 0, 1'b0, 32'h8000_0010, 32'h0,         4'hF, 32'hDEAD_AAEF, 1'b1, 4};
        vecs[12] = '{1, 1, 1'b0, 32'h7FFF_FFFC, 32'h0,         4'hF, 32'h0,          1'b0, 4};

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack0), 32'h0);
        check("rst_err", 32'(err0), 32'h0);
        check("rst_dat_p0", dto0[31:0], 32'h0);
        check("rst_dat_p1", dto0[63:32], 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            wb_xfer(vecs[i].d, vecs[i].p, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].s,
                    rd, ak, er, lat);
            check($sformatf("v%0d_ack", i), 32'(ak), 32'(vecs[i].exp_ack));
            check($sformatf("v%0d_err", i), 32'(er), 32'(!vecs[i].exp_ack));
`ifndef WB_RAM_STALL_INJECT_EN
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
`endif
            if (!vecs[i].w || !vecs[i].exp_ack) begin
                check($sformatf("v%0d_dat", i), rd, vecs[i].exp_rd);
            end
        end

`ifndef WB_RAM_STALL_INJECT_EN
        // Same-cycle writes: per byte the higher port wins.
        dual_op("coll_full", 32'h8000_0000, 2'b11, 32'h1111_1111, 4'hF, 32'h2222_2222, 4'hF, rd);
        wb_xfer(0, 0, 1'b0, 32'h8000_0000, 32'h0, 4'hF, rd, ak, er, lat);
        check("coll_full_rd", rd, 32'h2222_2222);
        dual_op("coll_part", 32'h8000_0004, 2'b11, 32'h1111_1111, 4'hF, 32'h2222_2222, 4'h3, rd);
        wb_xfer(0, 1, 1'b0, 32'h8000_0004, 32'h0, 4'hF, rd, ak, er, lat);
        check("coll_part_rd", rd, 32'h1111_2222);
        // Port 0 reads while port 1 writes the same word: old data returned.
        dual_op("rd_wr", 32'h8000_0000, 2'b10, 32'h0, 4'hF, 32'h3333_3333, 4'hF, rd);
        check("rd_wr_old", rd, 32'h2222_2222);
        wb_xfer(0, 0, 1'b0, 32'h8000_0000, 32'h0, 4'hF, rd, ak, er, lat);
        check("rd_wr_new", rd, 32'h3333_3333);

        // Wrap-4 read burst starting mid-block.
        for (int i = 0; i < 4; i++) begin
            wb_xfer(0, 1, 1'b1, 32'h8000_0030 + 32'(i * 4), 32'hA0A0_A030 + 32'(i * 4), 4'hF,
                    rd, ak, er, lat);
        end
        exp_w[0] = 32'hA0A0_A038;
        exp_w[1] = 32'hA0A0_A03C;
        exp_w[2] = 32'hA0A0_A030;
        exp_w[3] = 32'hA0A0_A034;
        adr[0][31:0] = 32'h8000_0038;
        cti[0][2:0]  = 3'b010;
        bte[0][1:0]  = 2'b01;
        we[0][0]  = 1'b0;
        cyc[0][0] = 1'b1;
        stb[0][0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) cti[0][2:0] = 3'b111;
            check($sformatf("wrap_ack%0d", i), 32'(ack0[0]), 32'h1);
            check($sformatf("wrap_dat%0d", i), dto0[31:0], exp_w[i]);
        end
        @(posedge clk);
        #1;
        check("wrap_end_ack", 32'(ack0[0]), 32'h0);
        cyc[0][0] = 1'b0;
        stb[0][0] = 1'b0;
        cti[0][2:0] = 3'b000;
        bte[0][1:0] = 2'b00;
        wb_xfer(0, 0, 1'b0, 32'h8000_0034, 32'h0, 4'hF, rd, ak, er, lat);
        check("post_wrap_lat", 32'(lat), 32'h1);
        check("post_wrap_rd", rd, 32'hA0A0_A034);

        // Reset asserted in the middle of a linear burst.
        adr[0][31:0] = 32'h8000_0030;
        cti[0][2:0]  = 3'b010;
        cyc[0][0] = 1'b1;
        stb[0][0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_ack_before", 32'(ack0[0]), 32'h1);
        check("mid_dat_before", dto0[31:0], 32'hA0A0_A034);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_ack", 32'(ack0[0]), 32'h0);
        check("rst_async_dat", dto0[31:0], 32'h0);
        cyc[0][0] = 1'b0;
        stb[0][0] = 1'b0;
        cti[0][2:0] = 3'b000;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        wb_xfer(0, 0, 1'b0, 32'h8000_0030, 32'h0, 4'hF, rd, ak, er, lat);
        check("after_rst_lat", 32'(lat), 32'h1);
        check("after_rst_rd", rd, 32'hA0A0_A030);
        wb_xfer(0, 1, 1'b0, 32'h8000_0010, 32'h0, 4'hF, rd, ak, er, lat);
        check("after_rst_rd2", rd, 32'hDEAD_BEEF);
`else
        begin
            int beat, g, expg;
            logic startp;
            for (int i = 0; i < 16; i++) begin
                wb_xfer(0, 1, 1'b1, 32'h8000_0100 + 32'(i * 4), 32'h5A00_0000 + 32'(i), 4'hF,
                        rd, ak, er, lat);
            end
            beat   = 0;
            g      = 0;
            expg   = 0;
            startp = 1'b1;
            adr[0][31:0] = 32'h8000_0100;
            cti[0][2:0]  = 3'b010;
            bte[0][1:0]  = 2'b00;
            we[0][0]  = 1'b0;
            cyc[0][0] = 1'b1;
            stb[0][0] = 1'b1;
            for (int c = 0; c < 200 && beat < 16; c++) begin
                @(posedge clk);
                #1;
                if (startp) begin
                    expg   = int'(m_prev[1:0]);
                    g      = 0;
                    startp = 1'b0;
                    if (beat == 15) cti[0][2:0] = 3'b111;
                end else begin
                    g++;
                end
                if (ack0[0]) begin
                    check($sformatf("stall_gap%0d", beat), 32'(g), 32'(expg));
                    check($sformatf("stall_dat%0d", beat), dto0[31:0], 32'h5A00_0000 + 32'(beat));
                    beat++;
                    startp = 1'b1;
                end
            end
            check("stall_beats", 32'(beat), 32'd16);
            @(posedge clk);
            #1;
            cyc[0][0] = 1'b0;
            stb[0][0] = 1'b0;
            cti[0][2:0] = 3'b000;
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
